// File: rtl/dmux_dispatch_ctrl.sv
// dmux_dispatch_ctrl: dispatches a valid/ready word stream into four one-entry
// channel registers, either round-robin from an internal pointer or directed
// by a destination field. Each channel is freed by its own consumer ack.
module dmux_dispatch_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       in_dest,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack,
    output logic [1:0]       sel,
    output logic [7:0]       count
);

    logic [1:0] ptr;
    logic [1:0] rr_target;
    logic       rr_found;
    logic [1:0] rr_idx;
    logic [1:0] target;
    logic       accept;

    // Round-robin search: first free channel at ptr, ptr+1, ptr+2, ptr+3.
    // Scanning the offsets downwards lets the smallest offset win.
    always_comb begin
        rr_target = ptr;
        rr_found  = 1'b0;
        rr_idx    = ptr;
        for (int k = 3; k >= 0; k--) begin
            rr_idx = ptr + 2'(k);
            if (!out_valid[rr_idx]) begin
                rr_target = rr_idx;
                rr_found  = 1'b1;
            end
        end
    end

    // Target selection and ready depend only on registered state, mode and
    // in_dest, never on in_valid.
    always_comb begin
        if (mode) begin
            target   = in_dest;
            in_ready = ~out_valid[in_dest];
        end else begin
            target   = rr_target;
            in_ready = rr_found;
        end
        accept = in_valid & in_ready;
    end

    // Control state: full flags, last select, accept counter and pointer.
    // Acks only clear flags that are set; the target is always free, so a
    // same-cycle ack on it cannot collide with the set.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 4'b0000;
            sel       <= 2'd0;
            count     <= 8'd0;
            ptr       <= 2'd0;
        end else begin
            out_valid <= (out_valid & ~out_ack) |
                         (accept ? (4'b0001 << target) : 4'b0000);
            if (accept) begin
                sel   <= target;
                count <= count + 8'd1;
                if (!mode) begin
                    ptr <= target + 2'd1;
                end
            end
        end
    end

    // Channel holding registers: loaded on accept, untouched by ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            a <= '0;
            b <= '0;
            c <= '0;
            d <= '0;
        end else if (accept) begin
            case (target)
                2'd0:    a <= in_data;
                2'd1:    b <= in_data;
                2'd2:    c <= in_data;
                default: d <= in_data;
            endcase
        end
    end

endmodule

// File: doc/dmux_dispatch_ctrl.md
# dmux_dispatch_ctrl

Sequencing controller for the 1-to-4, 4-bit demultiplexer datapath. Accepts a stream of 4-bit words over a valid/ready handshake and dispatches each word to one of four output channels (a, b, c, d). Each channel has a one-entry holding register with its own valid/ack handshake. Dispatch is either round-robin or directed by a destination field. The block sits between a single producer and four consumers, and generates the demux select plus the per-channel storage.

## Interface

Parameters:
- WIDTH, 4, data width of the input word and of each channel register

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a word on in_data
- in_data  in  WIDTH  word to dispatch
- in_ready  out  1  controller accepts in_data this cycle
- mode  in  1  0 = round-robin dispatch, 1 = directed dispatch
- in_dest  in  2  target channel when mode=1 (0=a, 1=b, 2=c, 3=d); ignored when mode=0
- a, b, c, d  out  WIDTH each  channel holding registers
- out_valid  out  4  per-channel full flag (bit0=a … bit3=d)
- out_ack  in  4  per-channel consumer acknowledge
- sel  out  2  channel written by the most recent accepted word
- count  out  8  number of accepted words, modulo 256

## Operation

- Channel i is free when out_valid[i]=0.
- Round-robin pointer ptr (2 bits, internal).
  - mode=0: the target is the first free channel found searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). in_ready=1 when any channel is free.
  - mode=1: the target is in_dest. in_ready=1 when channel in_dest is free.
- Accept occurs when in_valid=1 and in_ready=1. On accept, at the next edge:
  - the target register is loaded with in_data;
  - out_valid[target] is set to 1;
  - sel is set to the target;
  - count is incremented and wraps 255→0.
- ptr update: in mode=0, ptr becomes target+1 (mod 4). In mode=1, ptr is unchanged.
- Ack rules:
  - out_ack[i]=1 while out_valid[i]=1 clears out_valid[i] at the next edge.
  - out_ack[i] while out_valid[i]=0 is ignored.
  - Register contents are not cleared by ack and hold their last value.
- Writing a channel and acking the same channel in one cycle cannot occur, because a full channel is never a target.
- Acks on other channels in the same cycle as an accept are applied independently.
- A mode change takes effect immediately in the in_ready/target logic and leaves ptr untouched.
- in_valid=1 with in_ready=0: the word is not taken and no state changes. The producer must hold in_data.

## Timing

- Reset values (rst=1 at an edge):
  - a=b=c=d=0, out_valid=4'b0000, sel=0, count=0, ptr=0.
  - in_ready reads 1 on the first cycle after reset, since all channels are free.
- Reset has priority over accept and ack in the same cycle. A reset issued mid-operation discards all held words.
- in_ready is combinational from registered state (out_valid, ptr) and from mode and in_dest. It never depends on in_valid.
- Latency: a word accepted at edge N is visible on its channel register, with out_valid set, after edge N.
- Throughput: one word per cycle while a free channel exists.
- An acked channel becomes free one cycle after the ack edge. There is no same-cycle reuse.

## Test plan

- Reset: hold rst=1 for 2 cycles with in_valid=1 and in_data=4'hF → after release, all channels are 0, out_valid=0000, count=0, in_ready=1.
- Round-robin fill: mode=0, no acks, send 1,2,3,4 on consecutive cycles → a=1, b=2, c=3, d=4, out_valid=1111, sel=3, count=4. in_ready=0 afterwards, and a held 5th word is not taken.
- Refill after ack: from the full state, pulse out_ack=0010, then send 5 → b=5, sel=1, and ptr moves to c. Next pulse out_ack=0101, then send 6 then 7 → c=6, then a=7 (search wraps).
- Directed blocking: mode=1, in_dest=2, c full, in_valid=1 → in_ready=0 and nothing changes. Ack c → the cycle after the ack edge in_ready=1 and c takes the word. ptr is unchanged.
- Count wrap: 256 accepts with immediate acks → count=0, and every channel holds its last written value.
- Reset mid-operation: out_valid=1011 and an accept pending in the same cycle as rst=1 → next edge all outputs return to reset values and the pending word is dropped.
